// File: rtl/dfu_boot_helper.sv
// Button debounce, press classification and warm-boot / soft-reset sequencing for iCE40 boards.
// wb_boot/wb_sel are wired to SB_WARMBOOT BOOT/{S1,S0}. The SB_IO pull-up for BTN_MODE 3 lives in the board top.
module dfu_boot_helper #(
    parameter int TIMER_WIDTH = 24,
    parameter int BTN_MODE    = 3,
    parameter int DFU_MODE    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boot_now,
    input  logic [1:0] boot_sel,
    input  logic       btn_pad,
    output logic       btn_val,
    output logic       rst_req,
    output logic       wb_boot,
    output logic [1:0] wb_sel
);
    localparam int DB_W = TIMER_WIDTH - 8;
    localparam logic PAD_IDLE = (BTN_MODE == 2) ? 1'b0 : 1'b1;
    localparam logic [TIMER_WIDTH-1:0] LONG_M1 = {1'b0, {(TIMER_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BOOTED} state_t;

    logic                   pad_meta, pad_sync, btn_lvl;
    logic [DB_W-1:0]        db_cnt, arm_cnt;
    logic                   armed, btn_val_q;
    logic [TIMER_WIDTH-1:0] press_cnt;
    logic                   long_evt, short_rel;
    logic                   btn_boot, btn_rst;
    logic [1:0]             btn_sel;
    state_t                 state, state_nxt;
    logic [1:0]             sel_nxt;
    logic                   boot_nxt, rst_nxt;

    // Synchronizer resets to the released pad level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_meta <= PAD_IDLE;
            pad_sync <= PAD_IDLE;
        end else begin
            pad_meta <= btn_pad;
            pad_sync <= pad_meta;
        end
    end

    always_comb begin
        case (BTN_MODE)
            1, 3:    btn_lvl = ~pad_sync;
            2:       btn_lvl = pad_sync;
            default: btn_lvl = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt  <= '0;
            btn_val <= 1'b0;
        end else if (btn_lvl != btn_val) begin
            if (db_cnt == '1) begin
                btn_val <= btn_lvl;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Arm only after a full window of settled release, so a button held through reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else if (!armed) begin
            if (btn_val || btn_lvl) begin
                arm_cnt <= '0;
            end else if (arm_cnt == '1) begin
                armed <= 1'b1;
            end else begin
                arm_cnt <= arm_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_cnt <= '0;
            btn_val_q <= 1'b0;
        end else begin
            btn_val_q <= btn_val;
            if (!btn_val)
                press_cnt <= '0;
            else if (!press_cnt[TIMER_WIDTH-1])
                press_cnt <= press_cnt + TIMER_WIDTH'(1);
        end
    end

    // press_cnt still holds the press length in the cycle after btn_val falls.
    assign long_evt  = btn_val && (press_cnt == LONG_M1);
    assign short_rel = btn_val_q && !btn_val && !press_cnt[TIMER_WIDTH-1];

    always_comb begin
        if (DFU_MODE == 0) begin
            btn_rst  = armed && short_rel;
            btn_boot = armed && long_evt;
            btn_sel  = 2'd1;
        end else begin
            btn_rst  = armed && long_evt;
            btn_boot = armed && short_rel;
            btn_sel  = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            wb_sel  <= 2'd0;
            wb_boot <= 1'b0;
            rst_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            wb_sel  <= sel_nxt;
            wb_boot <= boot_nxt;
            rst_req <= rst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = wb_sel;
        boot_nxt  = wb_boot;
        rst_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (boot_now) begin
                    sel_nxt   = boot_sel;
                    state_nxt = ST_LOAD;
                end else if (btn_boot) begin
                    sel_nxt   = btn_sel;
                    state_nxt = ST_LOAD;
                end else begin
                    rst_nxt = btn_rst;
                end
            end
            ST_LOAD: begin
                boot_nxt  = 1'b1;
                state_nxt = ST_BOOTED;
            end
            ST_BOOTED: ;
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dfu_boot_helper.sv
// Directed bench: vector table on a DFU_MODE=0 instance, plus hand sequences for DFU_MODE=1,
// button held through reset, and BTN_MODE=0.
module tb_dfu_boot_helper;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       boot_now = 1'b0;
    logic [1:0] boot_sel = 2'd0;
    logic       pad_a = 1'b1, pad_b = 1'b1, pad_c = 1'b1;
    logic       now_off = 1'b0;
    logic [1:0] sel_off = 2'd0;

    logic       btn_a, rq_a, wbb_a, btn_b, rq_b, wbb_b, btn_c, rq_c, wbb_c;
    logic [1:0] wbs_a, wbs_b, wbs_c;

    int pa = 0, pb = 0, pc = 0;
    int ba = 0, bb = 0, bc = 0;
    int nvec = 0, nmis = 0;

    always #5 clk = ~clk;

    dfu_boot_helper #(.TIMER_WIDTH(12), .BTN_MODE(3), .DFU_MODE(0)) u_a (
        .clk(clk), .rst(rst), .boot_now(boot_now), .boot_sel(boot_sel), .btn_pad(pad_a),
        .btn_val(btn_a), .rst_req(rq_a), .wb_boot(wbb_a), .wb_sel(wbs_a));
    dfu_boot_helper #(.TIMER_WIDTH(12), .BTN_MODE(3), .DFU_MODE(1)) u_b (
        .clk(clk), .rst(rst), .boot_now(now_off), .boot_sel(sel_off), .btn_pad(pad_b),
        .btn_val(btn_b), .rst_req(rq_b), .wb_boot(wbb_b), .wb_sel(wbs_b));
    dfu_boot_helper #(.TIMER_WIDTH(12), .BTN_MODE(0), .DFU_MODE(0)) u_c (
        .clk(clk), .rst(rst), .boot_now(now_off), .boot_sel(sel_off), .btn_pad(pad_c),
        .btn_val(btn_c), .rst_req(rq_c), .wb_boot(wbb_c), .wb_sel(wbs_c));

    always @(posedge clk) begin
        if (rq_a) pa++;
        if (rq_b) pb++;
        if (rq_c) pc++;
    end

    typedef struct {
        bit         rst;
        bit         now;
        logic [1:0] sel;
        bit         pad;
        int         n;
        bit         e_btn;
        bit         e_wb;
        logic [1:0] e_sel;
        int         e_p;
    } vec_t;

    vec_t vq[$];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ep is the number of rst_req cycles seen since the previous check of that instance
    task automatic chk(input string nm, input int inst, input bit eb, input bit ew,
                       input logic [1:0] es, input int ep);
        logic       gb, gw;
        logic [1:0] gs;
        int         gp;
        case (inst)
            0: begin gb = btn_a; gw = wbb_a; gs = wbs_a; gp = pa - ba; ba = pa; end
            1: begin gb = btn_b; gw = wbb_b; gs = wbs_b; gp = pb - bb; bb = pb; end
            default: begin gb = btn_c; gw = wbb_c; gs = wbs_c; gp = pc - bc; bc = pc; end
        endcase
        nvec++;
        if ({gb, gw, gs} !== {eb, ew, es} || gp != ep) begin
            nmis++;
            $display("FAIL %s: btn_val/wb_boot/wb_sel/rst_req_pulses got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     nm, gb, gw, gs, gp, eb, ew, es, ep);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        ba = pa; bb = pb; bc = pc;
    endtask

    initial begin
        //                 rst now sel pad    n  btn wb sel pulses
        vq.push_back(vec_t'{1, 0, 2'd0, 1,    3, 0, 0, 2'd0, 0});  // reset state
        vq.push_back(vec_t'{0, 1, 2'd3, 1,    1, 0, 0, 2'd3, 0});  // sw boot: sel loads
        vq.push_back(vec_t'{0, 0, 2'd3, 1,    1, 0, 1, 2'd3, 0});  // BOOT one cycle later
        vq.push_back(vec_t'{0, 1, 2'd0, 1,    5, 0, 1, 2'd3, 0});  // frozen
        vq.push_back(vec_t'{1, 0, 2'd0, 1,    2, 0, 0, 2'd0, 0});  // reset clears latch
        vq.push_back(vec_t'{0, 0, 2'd0, 1,   20, 0, 0, 2'd0, 0});  // arm
        vq.push_back(vec_t'{0, 0, 2'd0, 0,   10, 0, 0, 2'd0, 0});  // bounce bursts
        vq.push_back(vec_t'{0, 0, 2'd0, 1,   10, 0, 0, 2'd0, 0});
        vq.push_back(vec_t'{0, 0, 2'd0, 0,   14, 0, 0, 2'd0, 0});
        vq.push_back(vec_t'{0, 0, 2'd0, 1,    8, 0, 0, 2'd0, 0});
        vq.push_back(vec_t'{0, 0, 2'd0, 0,   17, 0, 0, 2'd0, 0});  // one short of 2+16
        vq.push_back(vec_t'{0, 0, 2'd0, 0,    1, 1, 0, 2'd0, 0});  // exactly 2+16
        vq.push_back(vec_t'{0, 0, 2'd0, 0,  482, 1, 0, 2'd0, 0});  // 500-cycle press
        vq.push_back(vec_t'{0, 0, 2'd0, 1,   17, 1, 0, 2'd0, 0});  // release debounce
        vq.push_back(vec_t'{0, 0, 2'd0, 1,    1, 0, 0, 2'd0, 0});
        vq.push_back(vec_t'{0, 0, 2'd0, 1,    5, 0, 0, 2'd0, 1});  // single rst_req
        vq.push_back(vec_t'{0, 0, 2'd0, 0, 2065, 1, 0, 2'd0, 0});  // long press, not yet
        vq.push_back(vec_t'{0, 0, 2'd0, 0,    1, 1, 0, 2'd1, 0});  // sel=1 while held
        vq.push_back(vec_t'{0, 0, 2'd0, 0,    1, 1, 1, 2'd1, 0});  // BOOT rises
        vq.push_back(vec_t'{0, 0, 2'd0, 1,   40, 0, 1, 2'd1, 0});  // release ignored

        foreach (vq[i]) begin
            rst      = vq[i].rst;
            boot_now = vq[i].now;
            boot_sel = vq[i].sel;
            pad_a    = vq[i].pad;
            step(vq[i].n);
            chk($sformatf("vec%0d", i), 0, vq[i].e_btn, vq[i].e_wb, vq[i].e_sel, vq[i].e_p);
        end
        boot_now = 1'b0;
        pad_a    = 1'b1;

        // DFU_MODE=1 short press -> warm-boot image 2 on release
        do_reset();
        step(20);
        pad_b = 1'b0; step(100);
        chk("dfu1_short_held", 1, 1, 0, 2'd0, 0);
        pad_b = 1'b1; step(19);
        chk("dfu1_short_sel", 1, 0, 0, 2'd2, 0);
        step(1);
        chk("dfu1_short_boot", 1, 0, 1, 2'd2, 0);
        step(10);
        chk("dfu1_short_frozen", 1, 0, 1, 2'd2, 0);

        // DFU_MODE=1 long press -> one rst_req, no boot, nothing on release
        do_reset();
        step(20);
        pad_b = 1'b0; step(2070);
        chk("dfu1_long_rst", 1, 1, 0, 2'd0, 1);
        step(500);
        chk("dfu1_long_hold", 1, 1, 0, 2'd0, 0);
        pad_b = 1'b1; step(40);
        chk("dfu1_long_release", 1, 0, 0, 2'd0, 0);

        // Button held through reset: disarmed until released
        pad_a = 1'b0;
        do_reset();
        step(2100);
        chk("held_reset_hold", 0, 1, 0, 2'd0, 0);
        pad_a = 1'b1; step(40);
        chk("held_reset_release", 0, 0, 0, 2'd0, 0);
        pad_a = 1'b0; step(100);
        chk("held_reset_press", 0, 1, 0, 2'd0, 0);
        pad_a = 1'b1; step(40);
        chk("held_reset_armed", 0, 0, 0, 2'd0, 1);

        // BTN_MODE=0: pad has no effect
        pad_c = 1'b0; step(50);
        chk("btn_unused_lo", 2, 0, 0, 2'd0, 0);
        pad_c = 1'b1; step(50);
        chk("btn_unused_hi", 2, 0, 0, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
